// File: rtl/rmii_arb_pkg.sv
// Shared constants for the RMII transmit arbiter: state encoding, default
// timing parameters and the byte counter width.
package rmii_arb_pkg;

    localparam int IFG_CYCLES_DEF      = 48;
    localparam int MAX_FRAME_BYTES_DEF = 1522;
    localparam int CNT_W               = 11;

    // state      | meaning
    // ST_IDLE    | no owner, arbitrating between pending sources
    // ST_XFER    | granted source streams bytes to the serializer
    // ST_DRAIN   | oversize frame truncated, remaining source bytes discarded
    // ST_GAP     | inter-frame gap timer running, no owner
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_XFER  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    typedef logic [CNT_W-1:0] byte_cnt_t;

endpackage

// File: rtl/rmii_tx_arbiter_if.sv
// Byte-stream bundle around the arbiter: two source ports and one TX port.
// master = arbiter side, slave = sources/serializer side.
interface rmii_tx_arbiter_if;

    logic [7:0] s0_data;
    logic       s0_valid;
    logic       s0_last;
    logic       s0_ready;
    logic [7:0] s1_data;
    logic       s1_valid;
    logic       s1_last;
    logic       s1_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;

    modport master (
        input  s0_data, s0_valid, s0_last,
        input  s1_data, s1_valid, s1_last,
        input  m_ready,
        output s0_ready, s1_ready,
        output m_data, m_valid, m_last
    );

    modport slave (
        output s0_data, s0_valid, s0_last,
        output s1_data, s1_valid, s1_last,
        output m_ready,
        input  s0_ready, s1_ready,
        input  m_data, m_valid, m_last
    );

endinterface

// File: rtl/rmii_ifg_timer.sv
// Inter-frame gap down-counter: load presets IFG_CYCLES-1, expire flags zero.
module rmii_ifg_timer
    import rmii_arb_pkg::*;
#(
    parameter int IFG_CYCLES = IFG_CYCLES_DEF
) (
    input  logic REF_CLK,
    input  logic arst_n,
    input  logic load,
    output logic expire
);

    localparam int W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    logic [W-1:0] count;

    always_ff @(posedge REF_CLK or negedge arst_n) begin
        if (!arst_n) begin
            count <= '0;
        end else if (load) begin
            count <= W'(IFG_CYCLES - 1);
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/rmii_tx_arbiter.sv
// Two-source round-robin frame arbiter feeding one RMII TX byte stream.
// Define RMII_TX_ARB_IFG_EN to insert the IFG_CYCLES inter-frame gap.
module rmii_tx_arbiter
    import rmii_arb_pkg::*;
#(
    parameter int IFG_CYCLES      = IFG_CYCLES_DEF,
    parameter int MAX_FRAME_BYTES = MAX_FRAME_BYTES_DEF
) (
    input  logic              REF_CLK,
    input  logic              arst_n,
    rmii_tx_arbiter_if.master bus,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              overrun_err
);

    localparam byte_cnt_t LAST_IDX = byte_cnt_t'(MAX_FRAME_BYTES - 1);

`ifdef RMII_TX_ARB_IFG_EN
    localparam logic [1:0] ST_END = ST_GAP;
`else
    localparam logic [1:0] ST_END = ST_IDLE;
`endif

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [1:0] grant_q;
    logic [1:0] grant_pick;
    logic       ptr_s1;        // s1 wins the next contention
    logic       armed;         // holds off the first grant to the second edge after reset
    byte_cnt_t  byte_cnt;

    logic       sel_s1;
    logic [7:0] src_data;
    logic       src_valid;
    logic       src_last;
    logic       src_ready;
    logic       in_xfer;
    logic       in_drain;
    logic       at_max;
    logic       xfer_fire;
    logic       drain_fire;
    logic       frame_end;
    logic       last_out;
    logic       gap_expire;

    assign sel_s1    = grant_q[1];
    assign src_data  = sel_s1 ? bus.s1_data  : bus.s0_data;
    assign src_valid = sel_s1 ? bus.s1_valid : bus.s0_valid;
    assign src_last  = sel_s1 ? bus.s1_last  : bus.s0_last;

    assign in_xfer    = (state == ST_XFER);
    assign in_drain   = (state == ST_DRAIN);
    assign at_max     = (byte_cnt == LAST_IDX);
    assign xfer_fire  = in_xfer & src_valid & bus.m_ready;
    assign drain_fire = in_drain & src_valid & src_last;
    assign last_out   = src_last | at_max;
    assign frame_end  = (xfer_fire & src_last) | drain_fire;

    assign bus.m_valid = in_xfer & src_valid;
    assign bus.m_data  = in_xfer ? src_data : 8'h00;
    assign bus.m_last  = in_xfer & src_valid & last_out;
    assign src_ready   = in_xfer ? bus.m_ready : in_drain;
    assign bus.s0_ready = src_ready & grant_q[0];
    assign bus.s1_ready = src_ready & grant_q[1];

    assign overrun_err = xfer_fire & at_max & ~src_last;
    assign grant       = grant_q;
    assign busy        = (state != ST_IDLE);

    always_comb begin
        grant_pick = 2'b01;
        if (bus.s0_valid && bus.s1_valid) begin
            grant_pick = ptr_s1 ? 2'b10 : 2'b01;
        end else if (bus.s1_valid) begin
            grant_pick = 2'b10;
        end
    end

`ifdef RMII_TX_ARB_IFG_EN
    rmii_ifg_timer #(
        .IFG_CYCLES (IFG_CYCLES)
    ) u_ifg_timer (
        .REF_CLK (REF_CLK),
        .arst_n  (arst_n),
        .load    (frame_end),
        .expire  (gap_expire)
    );
`else
    logic ifg_unused;
    assign ifg_unused = (IFG_CYCLES == 0);
    assign gap_expire = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (armed && (bus.s0_valid || bus.s1_valid)) state_nxt = ST_XFER;
            end
            ST_XFER: begin
                if (xfer_fire) begin
                    if (src_last)    state_nxt = ST_END;
                    else if (at_max) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_fire) state_nxt = ST_END;
            end
            default: begin
                if (gap_expire) state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge REF_CLK or negedge arst_n) begin
        if (!arst_n) begin
            state    <= ST_IDLE;
            grant_q  <= 2'b00;
            ptr_s1   <= 1'b0;
            armed    <= 1'b0;
            byte_cnt <= '0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            if (state == ST_IDLE && state_nxt == ST_XFER) begin
                grant_q  <= grant_pick;
                byte_cnt <= '0;
            end else begin
                if (frame_end) grant_q <= 2'b00;
                if (xfer_fire) byte_cnt <= byte_cnt + 1'b1;
            end
            // a truncated frame also counts as served
            if (xfer_fire && last_out) ptr_s1 <= ~sel_s1;
        end
    end

endmodule

// File: tb/tb_rmii_tx_arbiter.sv
// Scoreboard bench for rmii_tx_arbiter: random frames and backpressure,
// frame-level round-robin reference model, reset and truncation cases.
module tb_rmii_tx_arbiter;
    import rmii_arb_pkg::*;

    localparam int IFG  = 48;
    localparam int MAXB = 1522;
`ifdef RMII_TX_ARB_IFG_EN
    localparam int GAP_LEN = IFG;
`else
    localparam int GAP_LEN = 0;
`endif
    localparam int EXP_GAP = GAP_LEN + 2;
    localparam int BOUND   = 8000;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } src_byte_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       ovr;
        logic [1:0] grant;
        logic       first;
        logic       b2b;
    } exp_t;

    logic       REF_CLK = 1'b0;
    logic       arst_n  = 1'b0;
    logic [1:0] grant;
    logic       busy;
    logic       overrun_err;

    rmii_tx_arbiter_if bus ();

    rmii_tx_arbiter #(
        .IFG_CYCLES      (IFG),
        .MAX_FRAME_BYTES (MAXB)
    ) dut (
        .REF_CLK     (REF_CLK),
        .arst_n      (arst_n),
        .bus         (bus),
        .grant       (grant),
        .busy        (busy),
        .overrun_err (overrun_err)
    );

    always #10 REF_CLK = ~REF_CLK;

    logic [7:0] sv_data  [2];
    logic       sv_valid [2];
    logic       sv_last  [2];
    logic       at_start [2];
    logic       fire_s   [2];
    logic       m_ready_r;
    int         m_mode;

    assign bus.s0_data  = sv_data[0];
    assign bus.s0_valid = sv_valid[0];
    assign bus.s0_last  = sv_last[0];
    assign bus.s1_data  = sv_data[1];
    assign bus.s1_valid = sv_valid[1];
    assign bus.s1_last  = sv_last[1];
    assign bus.m_ready  = m_ready_r;

    src_byte_t src_q [2][$];
    int        plen  [2][$];
    exp_t      exp_q [$];

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   bytes_out = 0;
    int   rise_cyc = 0;
    int   end_cyc  = -100000;
    logic [1:0] prev_grant = 2'b00;
    logic pref_s1 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge REF_CLK) cyc++;

    // source drivers and TX backpressure, updated just after each edge
    initial begin
        for (int s = 0; s < 2; s++) begin
            sv_data[s] = 8'h00; sv_valid[s] = 1'b0; sv_last[s] = 1'b0;
            at_start[s] = 1'b1; fire_s[s] = 1'b0;
        end
        m_ready_r = 1'b1;
        m_mode = 0;
    end

    always @(negedge REF_CLK) begin
        fire_s[0] = sv_valid[0] & bus.s0_ready;
        fire_s[1] = sv_valid[1] & bus.s1_ready;
    end

    always @(posedge REF_CLK) begin
        #1;
        for (int s = 0; s < 2; s++) begin
            if (fire_s[s] && src_q[s].size() > 0) begin
                at_start[s] = src_q[s][0].last;
                void'(src_q[s].pop_front());
            end
            if (src_q[s].size() > 0 && (at_start[s] || $urandom_range(0, 3) != 0)) begin
                sv_valid[s] = 1'b1;
                sv_data[s]  = src_q[s][0].data;
                sv_last[s]  = src_q[s][0].last;
            end else begin
                sv_valid[s] = 1'b0;
                sv_data[s]  = 8'h00;
                sv_last[s]  = 1'b0;
            end
        end
        case (m_mode)
            0:       m_ready_r = 1'b1;
            1:       m_ready_r = ~m_ready_r;
            default: m_ready_r = ($urandom_range(0, 3) != 0);
        endcase
    end

    // monitor: pops the scoreboard on every accepted output byte
    always @(negedge REF_CLK) begin
        exp_t e;
        if (arst_n) begin
            if (grant != 2'b00 && prev_grant == 2'b00) rise_cyc = cyc;
            prev_grant = grant;
            chk("s0_ready_ungranted", bus.s0_ready & ~grant[0], 0);
            chk("s1_ready_ungranted", bus.s1_ready & ~grant[1], 0);
            if (cyc > end_cyc && cyc - end_cyc <= GAP_LEN) chk("busy_in_gap", busy, 1);
            if (bus.m_valid) begin
                chk("granted_ready", grant[0] ? bus.s0_ready : bus.s1_ready, bus.m_ready);
                chk("busy_xfer", busy, 1);
            end
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_data", bus.m_data, e.data);
                    chk("m_last", bus.m_last, e.last);
                    chk("grant", grant, e.grant);
                    chk("overrun_err", overrun_err, e.ovr);
                    if (e.first && e.b2b) chk("frame_gap", rise_cyc - end_cyc, EXP_GAP);
                end
                if (bus.m_last) end_cyc = cyc;
                bytes_out++;
            end else begin
                chk("overrun_quiet", overrun_err, 0);
            end
        end
    end

    // frame-level reference: round-robin between pending frames, truncation at MAXB
    task automatic launch();
        src_byte_t b;
        src_byte_t mdl [2][$];
        exp_t      e;
        int s, len, n, k;
        logic trunc_prev;
        for (int si = 0; si < 2; si++) begin
            foreach (plen[si][f]) begin
                for (int i = 0; i < plen[si][f]; i++) begin
                    b.data = 8'($urandom_range(0, 255));
                    b.last = (i == plen[si][f] - 1);
                    src_q[si].push_back(b);
                    mdl[si].push_back(b);
                end
            end
        end
        k = 0;
        trunc_prev = 1'b0;
        while (plen[0].size() > 0 || plen[1].size() > 0) begin
            if (plen[0].size() > 0 && plen[1].size() > 0) s = pref_s1 ? 1 : 0;
            else s = (plen[1].size() > 0) ? 1 : 0;
            len = plen[s].pop_front();
            n = (len > MAXB) ? MAXB : len;
            for (int i = 0; i < len; i++) begin
                b = mdl[s].pop_front();
                if (i < n) begin
                    e.data  = b.data;
                    e.last  = (i == n - 1);
                    e.ovr   = (len > MAXB) && (i == n - 1);
                    e.grant = (s == 1) ? 2'b10 : 2'b01;
                    e.first = (i == 0);
                    e.b2b   = (k > 0) && !trunc_prev;
                    exp_q.push_back(e);
                end
            end
            pref_s1 = (s == 0);
            trunc_prev = (len > MAXB);
            k++;
        end
    endtask

    task automatic wait_done(input string name);
        int k;
        for (k = 0; k < BOUND; k++) begin
            @(negedge REF_CLK);
            if (exp_q.size() == 0 && src_q[0].size() == 0 && src_q[1].size() == 0 && !busy) break;
        end
        chk({name, "_completed"}, (k < BOUND), 1);
        if (k >= BOUND) begin
            exp_q.delete();
            src_q[0].delete();
            src_q[1].delete();
        end
        repeat (2) @(negedge REF_CLK);
    endtask

    task automatic run(input string name, input int mode);
        m_mode = mode;
        @(negedge REF_CLK);
        launch();
        wait_done(name);
    endtask

    initial begin
        int start;
        int nf;
        arst_n = 1'b0;
        repeat (3) @(negedge REF_CLK);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_overrun", overrun_err, 0);
        arst_n = 1'b1;
        repeat (2) @(negedge REF_CLK);

        // contention straight after reset: s0 first, then s1
        plen[0].push_back(64); plen[1].push_back(64);
        run("contend_after_reset", 0);

        // lone 64-byte s0 frame, then contention again: s1 now wins
        plen[0].push_back(64);
        run("single_s0", 0);
        plen[0].push_back(20); plen[1].push_back(30);
        run("contend_repeat", 2);

        // m_ready toggling every cycle
        plen[0].push_back(10);
        run("toggle_ready", 1);

        // exact maximum passes whole, oversize is truncated and drained
        plen[0].push_back(MAXB);
        run("max_frame", 0);
        plen[1].push_back(1600);
        run("oversize", 2);

        for (int r = 0; r < 6; r++) begin
            for (int s = 0; s < 2; s++) begin
                nf = $urandom_range(0, 3);
                for (int f = 0; f < nf; f++) plen[s].push_back($urandom_range(1, 40));
            end
            run("random_mix", 2);
        end

        // back-to-back s0 frames leave the pointer favouring s1 before reset
        plen[0].push_back(16); plen[0].push_back(16);
        run("b2b_s0", 0);

        // reset in the middle of an s1 frame
        m_mode = 0;
        @(negedge REF_CLK);
        plen[1].push_back(40);
        launch();
        start = bytes_out;
        for (int k = 0; k < BOUND; k++) begin
            @(negedge REF_CLK);
            if (bytes_out - start >= 20) break;
        end
        chk("reached_byte20", (bytes_out - start >= 20), 1);
        @(posedge REF_CLK);
        #5;
        arst_n = 1'b0;
        #1;
        chk("arst_m_valid", bus.m_valid, 0);
        chk("arst_m_last", bus.m_last, 0);
        chk("arst_m_data", bus.m_data, 0);
        chk("arst_grant", grant, 0);
        chk("arst_busy", busy, 0);
        chk("arst_overrun", overrun_err, 0);
        chk("arst_s0_ready", bus.s0_ready, 0);
        chk("arst_s1_ready", bus.s1_ready, 0);
        src_q[0].delete(); src_q[1].delete(); exp_q.delete();
        for (int s = 0; s < 2; s++) begin
            at_start[s] = 1'b1; sv_valid[s] = 1'b0; sv_last[s] = 1'b0; sv_data[s] = 8'h00;
        end
        pref_s1 = 1'b0;
        prev_grant = 2'b00;
        end_cyc = -100000;
        @(negedge REF_CLK);
        plen[0].push_back(12); plen[1].push_back(12);
        launch();
        repeat (2) @(negedge REF_CLK);
        arst_n = 1'b1;
        @(posedge REF_CLK);
        #1;
        chk("grant_first_edge", grant, 0);
        @(posedge REF_CLK);
        #1;
        chk("grant_second_edge", grant, 2'b01);
        wait_done("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
